// File: rtl/eth_pkg.sv
// eth_pkg: state encoding and constants shared by the MII transmit and receive stages
package eth_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA_LO, DATA_HI, FCS, IFG} tx_state_t;
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: combinational reflected CRC-32 update of one byte
// crc_in: running CRC, data: byte to fold in (LSB first), crc_out: updated CRC
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC_POLY : crc_out >> 1;
  end
endmodule

// File: rtl/raw_frame_mii_tx.sv
// raw_frame_mii_tx: sends committed FIFO frames on MII with preamble, SFD, FCS and IFG
// fifo_do/fifo_empty/fifo_re: 9-bit frame FIFO read side (bit 8 marks last byte)
// frame_commit: pulse per completed frame written; mii_txd/txen/txer: MII transmit
// busy: not idle; underrun: pulse when a needed byte is missing
module raw_frame_mii_tx
  import eth_pkg::*;
#(
  parameter int PRE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] fifo_do,
  input  logic       fifo_empty,
  output logic       fifo_re,
  input  logic       frame_commit,
  output logic [3:0] mii_txd,
  output logic       mii_txen,
  output logic       mii_txer,
  output logic       busy,
  output logic       underrun
);
  tx_state_t state;
  logic [CNT_W-1:0] frm_cnt;
  logic [7:0] cnt;
  logic [31:0] crc, crc_next, crc_inv;
  logic [7:0] byte_r;
  logic eof_r, err_r, eof_in, underrun_now, txen_d;
  logic [3:0] txd_d;
  crc32_byte u_crc (.crc_in(crc), .data(fifo_do[7:0]), .crc_out(crc_next));
  // outputs are registered from the current state, so the MII stream lags the FSM by one cycle
  always_comb begin
    eof_in = state == DATA_LO && fifo_do[8];
    underrun_now = state == DATA_HI && !eof_r && fifo_empty;
    fifo_re = state == SFD || (state == DATA_HI && !eof_r && !fifo_empty);
    crc_inv = ~crc >> {cnt[2:0], 2'b00};
    txd_d = state == PRE ? PREAMBLE_NIB : state == SFD ? SFD_NIB : state == DATA_LO ? fifo_do[3:0] :
            state == DATA_HI ? byte_r[7:4] : state == FCS ? crc_inv[3:0] : 4'h0;
    txen_d = state inside {PRE, SFD, DATA_LO, DATA_HI, FCS} || (state == IFG && err_r);
  end
  // err_r marks the single txer cycle that opens the IFG after an underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      frm_cnt <= '0;
      crc <= CRC_INIT;
      byte_r <= '0;
      eof_r <= 1'b0;
      err_r <= 1'b0;
      mii_txd <= 4'h0;
      mii_txen <= 1'b0;
      mii_txer <= 1'b0;
      busy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      mii_txd <= txd_d;
      mii_txen <= txen_d;
      mii_txer <= state == IFG && err_r;
      busy <= state != IDLE;
      underrun <= underrun_now;
      if (frame_commit && !eof_in && !(&frm_cnt)) frm_cnt <= frm_cnt + CNT_W'(1);
      else if (eof_in && !frame_commit && |frm_cnt) frm_cnt <= frm_cnt - CNT_W'(1);
      case (state)
        IDLE: if (|frm_cnt) begin
          state <= PRE;
          cnt <= '0;
        end
        PRE: if (cnt == 8'(PRE_NIBBLES - 1)) begin
          state <= SFD;
          cnt <= '0;
        end else cnt <= cnt + 8'd1;
        SFD: begin
          crc <= CRC_INIT;
          state <= DATA_LO;
        end
        DATA_LO: begin
          byte_r <= fifo_do[7:0];
          eof_r <= fifo_do[8];
          crc <= crc_next;
          state <= DATA_HI;
        end
        DATA_HI: begin
          cnt <= '0;
          err_r <= !eof_r && fifo_empty;
          state <= eof_r ? FCS : fifo_empty ? IFG : DATA_LO;
        end
        FCS: if (cnt == 8'd7) begin
          state <= IFG;
          cnt <= '0;
        end else cnt <= cnt + 8'd1;
        IFG: if (err_r) err_r <= 1'b0;
        else if (cnt == 8'(IFG_NIBBLES - 1)) state <= IDLE;
        else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
